// File: rtl/seq_player_ctrl.sv
// Pattern sequencer: debounced up/down buttons select a sequence, step_tick walks
// through its steps, each step word is fetched from a 1-cycle-latency ROM onto LEDS.
module seq_player_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic pb,
  output logic press
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // press fires on the same edge the debounced level rises, so it is already registered
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= pb;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_b;
        cnt   <= '0;
        press <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module seq_player_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int STEPS     = 16,
  parameter int NUM_SEQ   = 8
) (
  input  logic                                        clk_50,
  input  logic                                        reset,
  input  logic                                        pb_seq_up,
  input  logic                                        pb_seq_dn,
  input  logic                                        step_tick,
  input  logic [7:0]                                  rom_data,
  output logic [$clog2(NUM_SEQ)+$clog2(STEPS)-1:0]    ROM_addr,
  output logic [$clog2(NUM_SEQ)-1:0]                  seq_num,
  output logic [7:0]                                  LEDS,
  output logic                                        busy
);
  localparam int SEQ_W  = $clog2(NUM_SEQ);
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic              up_evt;
  logic              dn_evt;
  logic              seq_chg;

  seq_player_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk_50 (clk_50),
    .reset  (reset),
    .pb     (pb_seq_up),
    .press  (up_evt)
  );

  seq_player_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk_50 (clk_50),
    .reset  (reset),
    .pb     (pb_seq_dn),
    .press  (dn_evt)
  );

  // simultaneous up and down presses cancel out
  assign seq_chg = up_evt ^ dn_evt;

  // a sequence change overrides whatever the FSM was doing, including a pending LATCH
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      seq_num <= '0;
      step    <= '0;
      LEDS    <= 8'h00;
    end else if (state == IDLE) begin
      state <= FETCH;
    end else if (seq_chg) begin
      seq_num <= up_evt ? seq_num + SEQ_W'(1) : seq_num - SEQ_W'(1);
      step    <= '0;
      state   <= FETCH;
    end else begin
      case (state)
        FETCH: state <= LATCH;
        LATCH: begin
          LEDS  <= rom_data;
          state <= HOLD;
        end
        HOLD: begin
          if (step_tick) begin
            step  <= step + STEP_W'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ROM_addr = {seq_num, step};
  assign busy     = (state == FETCH) || (state == LATCH);
endmodule

// File: doc/seq_player_ctrl.md
SEQ_PLAYER_CTRL -- requirements
Module: seq_player_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000, meaning debounce stability window in clk_50 cycles (10 ms at 50 MHz).
REQ-002 Parameter STEPS, default 16, meaning steps per sequence; it SHALL be a power of two, at least 2.
REQ-003 Parameter NUM_SEQ, default 8, meaning number of sequences; it SHALL be a power of two, at least 2.
REQ-004 Port clk_50  input  1  meaning sole clock; all logic SHALL be clocked on the rising edge.
REQ-005 Port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 Port pb_seq_up  input  1  meaning raw pushbutton for next sequence; active-high, asynchronous to clk_50, bouncy.
REQ-007 Port pb_seq_dn  input  1  meaning raw pushbutton for previous sequence; same properties as pb_seq_up.
REQ-008 Port step_tick  input  1  meaning single-cycle step enable from the slow-clock divider, synchronous to clk_50.
REQ-009 Port rom_data  input  8  meaning pattern ROM read data; valid 1 cycle after ROM_addr is presented.
REQ-010 Port ROM_addr  output  log2(NUM_SEQ)+log2(STEPS)  meaning {seq_num, step}.
REQ-011 Port seq_num  output  log2(NUM_SEQ)  meaning currently selected sequence.
REQ-012 Port LEDS  output  8  meaning displayed pattern.
REQ-013 Port busy  output  1  meaning high while a ROM fetch is in flight (FETCH or LATCH state).

Function
REQ-014 Each pushbutton SHALL pass a 2-FF synchronizer, then a debounce counter.
REQ-015 The debounced level SHALL change only after the synchronized input has held the new value for DB_CYCLES consecutive cycles.
REQ-016 A press event SHALL be a single-cycle pulse on the rising edge of the debounced level. Release events SHALL be ignored.
REQ-017 An up event alone SHALL increment seq_num modulo NUM_SEQ (NUM_SEQ-1 wraps to 0).
REQ-018 A down event alone SHALL decrement seq_num modulo NUM_SEQ (0 wraps to NUM_SEQ-1).
REQ-019 Up and down events in the same cycle SHALL leave seq_num unchanged and SHALL NOT restart playback.
REQ-020 FSM states SHALL be IDLE, FETCH, LATCH and HOLD.
REQ-021 IDLE SHALL go to FETCH on the first cycle after reset is released.
REQ-022 FETCH SHALL drive ROM_addr and go to LATCH on the next cycle.
REQ-023 LATCH SHALL load LEDS with rom_data and go to HOLD on the next cycle.
REQ-024 HOLD SHALL hold LEDS and step.
REQ-025 On step_tick in HOLD, step SHALL increment modulo STEPS (STEPS-1 wraps to 0) and the FSM SHALL go to FETCH.
REQ-026 step_tick in any state other than HOLD SHALL be ignored (not queued).
REQ-027 A valid sequence change (REQ-017 or REQ-018) in any non-IDLE state SHALL, on the same clock edge, update seq_num, clear step to 0 and go to FETCH.
REQ-028 A fetch aborted by a sequence change SHALL NOT update LEDS.
REQ-029 A sequence change coinciding with step_tick in HOLD SHALL take priority: step becomes 0, not step+1.
REQ-030 A sequence change's first new pattern SHALL appear on LEDS 3 cycles after the event: edge 1 FETCH, edge 2 LATCH, edge 3 LEDS updated.
REQ-031 ROM_addr SHALL always equal {seq_num, step} as registered values.
REQ-032 busy SHALL equal (state==FETCH or state==LATCH).

Reset
REQ-033 Asserting reset SHALL immediately force: state IDLE, seq_num 0, step 0, LEDS 8'h00, busy 0, ROM_addr 0.
REQ-034 Asserting reset SHALL also clear all synchronizer, debounce counter and debounced-level registers.
REQ-035 Reset asserted mid-fetch or mid-debounce SHALL discard the pending operation; no event SHALL fire on reset release even if a button is held.

Verification
REQ-036 Reset release, ROM returns 8'hA5 at address 0 -> busy high 2 cycles, then LEDS=8'hA5 and state HOLD; 3 step_ticks -> ROM_addr=7'h03.
REQ-037 Hold step=15 (STEPS=16), seq_num=2, pulse step_tick -> ROM_addr=7'h20, LEDS loads the address-0x20 word.
REQ-038 Bouncy pb_seq_up with glitches shorter than DB_CYCLES, then stable high for DB_CYCLES -> exactly one increment; seq_num 7 -> 0.
REQ-039 Down press at seq_num=0 -> seq_num=7, step=0, ROM_addr=7'h70; simultaneous up+down debounced edges -> no change.
REQ-040 Sequence change in the same cycle as step_tick in HOLD -> step=0, FETCH next.
REQ-041 Sequence change during LATCH -> stale word not shown; LEDS updates only from the new address.
REQ-042 Reset pulse asserted while in LATCH with a button held -> all outputs 0 immediately; no seq_num change after release until a new full debounced press.
